// File: rtl/gates_sweep_pkg.sv
// Shared types and constants for the gate-block input sweeper.
package gates_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned LED_AND  = 0;
  localparam int unsigned LED_NAND = 1;
  localparam int unsigned LED_OR   = 2;
  localparam int unsigned LED_NOR  = 3;
  localparam int unsigned LED_XOR  = 4;
  localparam int unsigned LED_XNOR = 5;

  localparam int unsigned PATTERNS = 16;

  // a[3] toggles fastest, so the sweep index is presented bit-reversed.
  function automatic logic [3:0] bit_rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  function automatic logic [5:0] expected_led(input logic [3:0] a);
    logic [5:0] e;
    e           = '0;
    e[LED_AND]  = &a;
    e[LED_NAND] = ~&a;
    e[LED_OR]   = |a;
    e[LED_NOR]  = ~|a;
    e[LED_XOR]  = ^a;
    e[LED_XNOR] = ~^a;
    return e;
  endfunction

endpackage

// File: rtl/gates_sweep_ctrl_key_debounce.sv
// Two-flop synchroniser plus stable-time debouncer for one active-low key;
// emits a 1-cycle press pulse on each accepted high-to-low transition.
module key_debounce #(
  parameter int unsigned CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = (CYC > 1) ? $clog2(CYC) : 1;

  logic [1:0]    r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic          w_key;
  logic          w_hit;

  assign w_key = r_sync[1];
  assign w_hit = (r_cnt == CW'(CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= 2'b11;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], key_n};
      r_press <= 1'b0;
      // Count consecutive cycles the synchronised level differs from the accepted one.
      if (w_key != r_stable) begin
        if (w_hit) begin
          r_stable <= w_key;
          r_cnt    <= '0;
          r_press  <= ~w_key;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign press = r_press;

endmodule

// File: rtl/gates_sweep_ctrl.sv
// Sweeps all 16 input patterns of four_in_gates, timer- or key-driven.
// Optional truth-table checking of led_in is enabled by GATES_SWEEP_SELF_CHECK_EN.
module gates_sweep_ctrl
  import gates_sweep_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 12_000_000,
  parameter int unsigned DWELL_MS    = 500,
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start_n,
  input  logic       key_pause_n,
  input  logic       key_step_n,
  input  logic       auto_mode,
  input  logic [5:0] led_in,
  output logic [3:0] a_out,
  output logic [3:0] idx,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned DWELL_CYC    = CLK_FREQ / 1000 * DWELL_MS;
  localparam int unsigned DEBOUNCE_CYC = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int unsigned DW           = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);
  localparam logic [3:0]    IDX_LAST   = 4'(PATTERNS - 1);

  state_e        r_state, w_state_nxt;
  logic [3:0]    r_idx, w_idx_nxt;
  logic [3:0]    r_a_out;
  logic [DW-1:0] r_dwell, w_dwell_nxt;
  logic          r_auto;
  logic          w_start, w_pause_raw, w_step_raw, w_pause, w_step;
  logic          w_auto_chg, w_adv, w_load, w_clr_err;

  key_debounce #(.CYC(DEBOUNCE_CYC)) u_key_start (
    .clk  (clk),
    .rst_n(rst_n),
    .key_n(key_start_n),
    .press(w_start)
  );

  key_debounce #(.CYC(DEBOUNCE_CYC)) u_key_pause (
    .clk  (clk),
    .rst_n(rst_n),
    .key_n(key_pause_n),
    .press(w_pause_raw)
  );

  key_debounce #(.CYC(DEBOUNCE_CYC)) u_key_step (
    .clk  (clk),
    .rst_n(rst_n),
    .key_n(key_step_n),
    .press(w_step_raw)
  );

  // Same-cycle presses resolve start > pause > step.
  assign w_pause    = w_pause_raw & ~w_start;
  assign w_step     = w_step_raw & ~w_start & ~w_pause_raw;
  assign w_auto_chg = (auto_mode != r_auto);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_dwell_nxt = r_dwell;
    w_adv       = 1'b0;
    w_load      = 1'b0;
    w_clr_err   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = RUN;
          w_idx_nxt   = '0;
          w_dwell_nxt = '0;
          w_load      = 1'b1;
        end
      end
      RUN: begin
        if (w_start) begin
          w_idx_nxt   = '0;
          w_dwell_nxt = '0;
          w_load      = 1'b1;
        end else begin
          // The pause-press cycle still counts as a run cycle before the count freezes.
          if (auto_mode) begin
            w_adv       = ~w_auto_chg && (r_dwell == DWELL_LAST);
            w_dwell_nxt = w_adv ? '0 : r_dwell + DW'(1);
          end else begin
            w_adv       = w_step;
            w_dwell_nxt = '0;
          end
          if (w_pause) w_state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (w_start) begin
          w_state_nxt = RUN;
          w_idx_nxt   = '0;
          w_dwell_nxt = '0;
          w_load      = 1'b1;
        end else if (w_pause) begin
          w_state_nxt = RUN;
        end else if (w_step) begin
          w_adv       = 1'b1;
          w_dwell_nxt = '0;
        end
      end
      DONE: begin
        if (w_start) begin
          w_state_nxt = RUN;
          w_idx_nxt   = '0;
          w_dwell_nxt = '0;
          w_load      = 1'b1;
          w_clr_err   = 1'b1;
        end
      end
    endcase
    if (w_adv) begin
      w_load = 1'b1;
      if (r_idx == IDX_LAST) begin
        w_state_nxt = DONE;
      end else begin
        w_idx_nxt = r_idx + 4'd1;
      end
    end
    if (w_auto_chg) w_dwell_nxt = '0;
  end

  always_comb begin
    busy = (r_state == RUN) || (r_state == PAUSE);
    done = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_a_out <= '0;
      r_dwell <= '0;
      r_auto  <= 1'b0;
    end else begin
      r_idx   <= w_idx_nxt;
      r_a_out <= bit_rev4(w_idx_nxt);
      r_dwell <= w_dwell_nxt;
      r_auto  <= auto_mode;
    end
  end

  assign a_out = r_a_out;
  assign idx   = r_idx;

`ifdef GATES_SWEEP_SELF_CHECK_EN
  logic [1:0] r_chk;
  logic       r_error;

  // led_in is compared two cycles after each a_out load to let the gate block settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk   <= '0;
      r_error <= 1'b0;
    end else begin
      r_chk <= {r_chk[0], w_load};
      if (w_clr_err) begin
        r_error <= 1'b0;
      end else if (r_chk[1] && (led_in != expected_led(r_a_out))) begin
        r_error <= 1'b1;
      end
    end
  end

  assign error = r_error;
`else
  logic w_unused_chk;
  assign w_unused_chk = ^{led_in, w_load, w_clr_err};
  assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_gates_sweep_ctrl.sv
// Self-checking bench for gates_sweep_ctrl (build with GATES_SWEEP_SELF_CHECK_EN to test checking).
module tb_gates_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_start_n = 1'b1;
  logic       key_pause_n = 1'b1;
  logic       key_step_n = 1'b1;
  logic       auto_mode = 1'b0;
  logic       fault_xor = 1'b0;
  logic [5:0] led_in;
  logic [3:0] a_out, idx;
  logic       busy, done, error;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [3:0] exp_q[$];
  int len_q[$];

`ifdef GATES_SWEEP_SELF_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  gates_sweep_ctrl #(
    .CLK_FREQ   (1000),
    .DWELL_MS   (5),
    .DEBOUNCE_MS(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_start_n(key_start_n),
    .key_pause_n(key_pause_n),
    .key_step_n (key_step_n),
    .auto_mode  (auto_mode),
    .led_in     (led_in),
    .a_out      (a_out),
    .idx        (idx),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural gate block: counts ones; optionally sticks the XOR LED low.
  function automatic logic [5:0] model_led(input logic [3:0] a, input logic fx);
    int n;
    logic [5:0] l;
    n = int'(a[0]) + int'(a[1]) + int'(a[2]) + int'(a[3]);
    l[0] = (n == 4);
    l[1] = (n != 4);
    l[2] = (n != 0);
    l[3] = (n == 0);
    l[4] = (n % 2 == 1) && !fx;
    l[5] = (n % 2 == 0);
    return l;
  endfunction

  always_comb led_in = model_led(a_out, fault_xor);

  task automatic set_key(input int k, input logic v);
    case (k)
      0: key_start_n = v;
      1: key_pause_n = v;
      default: key_step_n = v;
    endcase
  endtask

  task automatic press_key(input int k);
    @(negedge clk);
    set_key(k, 1'b0);
    repeat (4) @(negedge clk);
    set_key(k, 1'b1);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (a_out !== 4'b0000) $display("FAIL reset_a_out: got %b want 0000", a_out); else n_pass++;
    n_checks++; if (idx !== 4'd0) $display("FAIL reset_idx: got %0d want 0", idx); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else n_pass++;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_idle: busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_auto_sweep;
    logic       inrun = 1'b0;
    logic [3:0] cur = '0;
    int         len = 0;
    logic       fin = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(4'((i % 2) * 8 + ((i / 2) % 2) * 4 + ((i / 4) % 2) * 2 + (i / 8)));
      len_q.push_back(5);
    end
    auto_mode = 1'b1;
    repeat (3) @(negedge clk);
    key_start_n = 1'b0;
    for (int i = 0; i < 200 && !fin; i++) begin
      @(negedge clk);
      if (i == 3) key_start_n = 1'b1;
      if (inrun && (!busy || a_out !== cur)) begin
        logic [3:0] ep;
        int el;
        ep = exp_q.pop_front();
        el = len_q.pop_front();
        n_checks++; if (cur !== ep) $display("FAIL auto_pattern: got %b want %b", cur, ep); else n_pass++;
        n_checks++;
        if (len != el) $display("FAIL auto_hold %b: got %0d cycles want %0d", cur, len, el);
        else n_pass++;
        cur = a_out;
        len = 1;
        if (!busy) fin = 1'b1;
      end else if (busy && !inrun) begin
        inrun = 1'b1;
        cur   = a_out;
        len   = 1;
      end else if (busy) begin
        len++;
      end
    end
    n_checks++; if (!fin) $display("FAIL auto_timeout: sweep end got %b want 1", fin); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL auto_left: got %0d want 0", exp_q.size()); else n_pass++;
    exp_q.delete();
    len_q.delete();
    n_checks++; if (done !== 1'b1) $display("FAIL auto_done: got %b want 1", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL auto_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (a_out !== 4'b1111) $display("FAIL auto_last: got %b want 1111", a_out); else n_pass++;
    n_checks++; if (error !== 1'b0) $display("FAIL auto_error: got %b want 0", error); else n_pass++;
  endtask

  task automatic test_done_ignores;
    press_key(2);
    press_key(1);
    n_checks++; if (done !== 1'b1) $display("FAIL done_hold: got %b want 1", done); else n_pass++;
    n_checks++; if (idx !== 4'd15) $display("FAIL done_idx: got %0d want 15", idx); else n_pass++;
    n_checks++; if (a_out !== 4'b1111) $display("FAIL done_a_out: got %b want 1111", a_out); else n_pass++;
  endtask

  task automatic test_manual_step;
    logic [3:0] e;
    auto_mode = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(4'd0);
    press_key(0);
    e = exp_q.pop_front();
    n_checks++; if (idx !== e) $display("FAIL manual_start_idx: got %0d want %0d", idx, e); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL manual_busy: got %b want 1", busy); else n_pass++;
    for (int s = 1; s <= 3; s++) begin
      exp_q.push_back(4'(s));
      press_key(2);
      e = exp_q.pop_front();
      n_checks++; if (idx !== e) $display("FAIL manual_step_idx: got %0d want %0d", idx, e); else n_pass++;
    end
    n_checks++; if (a_out !== 4'b1100) $display("FAIL manual_a_out: got %b want 1100", a_out); else n_pass++;
    repeat (30) @(negedge clk);
    n_checks++; if (idx !== 4'd3) $display("FAIL manual_hold: got %0d want 3", idx); else n_pass++;
  endtask

  task automatic test_simultaneous;
    @(negedge clk);
    key_start_n = 1'b0;
    key_step_n  = 1'b0;
    repeat (4) @(negedge clk);
    key_start_n = 1'b1;
    key_step_n  = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++; if (idx !== 4'd0) $display("FAIL simul_idx: got %0d want 0", idx); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL simul_busy: got %b want 1", busy); else n_pass++;
    @(negedge clk);
    key_step_n = 1'b0;
    @(negedge clk);
    key_step_n = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++; if (idx !== 4'd0) $display("FAIL glitch_idx: got %0d want 0", idx); else n_pass++;
  endtask

  task automatic test_pause;
    logic [3:0] p0, k;
    int t0 = -1, t1 = -1, t2 = -1, pf, rf;
    logic held = 1'b1;
    auto_mode = 1'b1;
    @(negedge clk);
    p0 = idx;
    for (int i = 0; i < 20 && t0 < 0; i++) begin
      @(negedge clk);
      if (idx !== p0) begin
        t0 = cyc;
        k  = idx;
      end
    end
    n_checks++; if (t0 < 0) $display("FAIL pause_sync: got no advance want advance"); else n_pass++;
    if (t0 >= 0) begin
      while (cyc < t0 + 3) @(negedge clk);
      key_pause_n = 1'b0;
      pf = cyc;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (i == 3) key_pause_n = 1'b1;
        if (t1 < 0 && idx !== k) t1 = cyc;
        if (i >= 15 && idx !== k + 4'd1) held = 1'b0;
      end
      n_checks++; if (t1 != t0 + 5) $display("FAIL pause_pre_hold: got %0d want %0d", t1, t0 + 5); else n_pass++;
      n_checks++; if (!held) $display("FAIL pause_frozen: idx got %0d want %0d", idx, k + 4'd1); else n_pass++;
      key_pause_n = 1'b0;
      rf = cyc;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (i == 3) key_pause_n = 1'b1;
        if (t2 < 0 && idx !== k + 4'd1) t2 = cyc;
      end
      n_checks++;
      if (t2 - t1 != 5 + (rf - pf))
        $display("FAIL pause_resume: hold got %0d want %0d", t2 - t1, 5 + (rf - pf));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_sweep;
    logic hit = 1'b0;
    press_key(0);
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (idx === 4'd7) hit = 1'b1;
    end
    n_checks++; if (!hit) $display("FAIL midrst_reach: got %0d want 7", idx); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (a_out !== 4'b0000) $display("FAIL midrst_a_out: got %b want 0000", a_out); else n_pass++;
    n_checks++; if (idx !== 4'd0) $display("FAIL midrst_idx: got %0d want 0", idx); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL midrst_done: got %b want 0", done); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || idx !== 4'd0) $display("FAIL midrst_idle: busy/idx got %b/%0d want 0/0", busy, idx);
    else n_pass++;
  endtask

  task automatic test_self_check;
    int ta = -1, te = -1;
    logic fin = 1'b0;
    auto_mode = 1'b1;
    fault_xor = 1'b1;
    @(negedge clk);
    key_start_n = 1'b0;
    for (int i = 0; i < 200 && !fin; i++) begin
      @(negedge clk);
      if (i == 3) key_start_n = 1'b1;
      if (ta < 0 && busy && a_out === 4'b1000) ta = cyc;
      if (te < 0 && error === 1'b1) te = cyc;
      if (done === 1'b1) fin = 1'b1;
    end
    n_checks++; if (!fin) $display("FAIL selfchk_timeout: done got %b want 1", done); else n_pass++;
    n_checks++; if (error !== EXP_ERR) $display("FAIL selfchk_error: got %b want %b", error, EXP_ERR); else n_pass++;
`ifdef GATES_SWEEP_SELF_CHECK_EN
    n_checks++; if (te - ta != 2) $display("FAIL selfchk_latency: got %0d want 2", te - ta); else n_pass++;
`endif
    fault_xor = 1'b0;
    press_key(0);
    n_checks++; if (error !== 1'b0) $display("FAIL selfchk_clear: got %b want 0", error); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL selfchk_restart: got %b want 1", busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_auto_sweep();
    test_done_ignores();
    test_manual_step();
    test_simultaneous();
    test_pause();
    test_reset_mid_sweep();
    test_self_check();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gates_sweep_ctrl.md
Name: gates_sweep_ctrl

Overview:
- Sequencer that drives the 4-bit input bus of the four-input gate block, `four_in_gates` (a[3:0] in, led[5:0] out), on the MAX10 board.
- Sweeps all 16 input combinations, either automatically on a dwell timer or one step per key press.
- Raw board keys come in; a[3:0] goes to `four_in_gates`, and status bits go to spare LEDs.
- With the optional feature compiled in, it also checks the gate outputs against a truth table.

Parameters:
- CLK_FREQ, 12_000_000, clock frequency in Hz.
- DWELL_MS, 500, hold time per pattern in auto mode, in ms.
- DEBOUNCE_MS, 20, key stable time required before a press is accepted, in ms.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- key_start_n  in  1  raw key, active-low; start, or restart from DONE.
- key_pause_n  in  1  raw key, active-low; toggles RUN/PAUSE.
- key_step_n  in  1  raw key, active-low; advances one pattern when auto_mode=0 or in PAUSE.
- auto_mode  in  1  switch level; 1 = timer-driven advance, 0 = manual advance.
- led_in  in  6  outputs of `four_in_gates`; used only by SELF_CHECK_EN.
- a_out  out  4  pattern driven onto a[3:0] of `four_in_gates`.
- idx  out  4  current sweep index, 0..15.
- busy  out  1  high in RUN or PAUSE.
- done  out  1  high in DONE.
- error  out  1  sticky mismatch flag; tied 0 without SELF_CHECK_EN.

Behaviour:
- Clock and reset:
  - All flops use clk and async rst_n.
  - Reset values: state=IDLE, idx=0, a_out=4'b0000, busy=0, done=0, error=0, dwell counter=0.
- Key handling:
  - Each key is synchronised with 2 flops, then debounced: it must be stable for DEBOUNCE_CYC = CLK_FREQ/1000*DEBOUNCE_MS cycles.
  - On each debounced high-to-low transition, a 1-cycle press pulse is produced.
- Pattern mapping:
  - a_out = {idx[0], idx[1], idx[2], idx[3]} (bit-reversed), so a[3] toggles fastest and a[0] slowest.
  - a_out is registered and updates in the same cycle as idx.
- FSM states: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - start press → RUN, with idx=0 and dwell counter cleared.
  - pause and step presses are ignored.
- RUN:
  - Advance event, auto_mode=1: dwell counter reaches DWELL_CYC-1, where DWELL_CYC = CLK_FREQ/1000*DWELL_MS. The counter then clears.
  - Advance event, auto_mode=0: a step press. The dwell counter is held at 0.
  - On advance with idx<15: idx increments.
  - On advance with idx=15: → DONE; idx stays 15 and a_out holds 4'b1111.
  - pause press → PAUSE; the dwell counter freezes.
  - start press → restart at idx=0.
- PAUSE:
  - pause press → RUN, resuming the frozen count.
  - step press advances one pattern, with the same idx=15 → DONE rule.
  - start press → RUN at idx=0.
- DONE:
  - a_out is held.
  - start press → RUN at idx=0 and clears error.
  - Other presses are ignored.
- Simultaneous presses in one cycle: priority start > pause > step.
- Switching auto_mode mid-RUN: takes effect the next cycle; the dwell counter clears on any change.
- Reset mid-sweep: returns immediately to the reset values; no output glitch beyond the async clear.

Optional Feature:
- Macro: GATES_SWEEP_SELF_CHECK_EN.
- Defined:
  - The expected vector is computed from a_out as {XNOR, XOR, NOR, OR, NAND, AND} of all four bits, at led bit positions [5:0].
  - led_in is sampled 2 cycles after each a_out update, allowing for combinational and routing settle.
  - Any mismatch sets error. error stays set until reset or a start press from DONE.
- Undefined:
  - led_in is unused, error is constant 0, and no compare logic is present.

Decomposition:
- Package gates_sweep_pkg:
  - state enum: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3.
  - LED bit-index constants: LED_AND=0, LED_NAND=1, LED_OR=2, LED_NOR=3, LED_XOR=4, LED_XNOR=5.
  - PATTERNS=16.
- Sub-module key_debounce, instantiated 3×:
  - Ports: clk, rst_n, key_n, press (1-cycle pulse).
  - Parameter: CYC.

Test Plan (sim params CLK_FREQ=1000, DWELL_MS=5, DEBOUNCE_MS=2: DWELL_CYC=5, DEBOUNCE_CYC=2):
- Reset mid-sweep: assert rst_n=0 at idx=7 → a_out=0, idx=0, busy=0, done=0 on the same edge; IDLE after release.
- Auto sweep: auto_mode=1, start press → a_out sequence 0000,1000,0100,1100,…,1111, each held exactly 5 cycles; then done=1, busy=0, a_out=1111.
- Manual step: auto_mode=0, start, 3 step presses → idx=3, a_out=4'b1100; no advance without a press.
- Pause: press pause at dwell count 2 in auto mode, wait 20 cycles → idx unchanged; pause again → advance after 2 more cycles.
- Simultaneous and bounce: start+step in the same cycle → idx=0 (start wins); a 1-cycle glitch on key_step_n → no press.
- Self-check (macro defined): model led_in with bit LED_XOR forced to 0 → error=1 at pattern 1000; error stays 1 through DONE and clears on start.
